dot_acc_sched: RTL and testbench

//  Sequences one dot16_16bit PE through a K-beat accumulation job. Interleaves PIPE_LAT independent

---
 rtl/dot_acc_sched.sv | 118 +++++++++++
 tb/tb_dot_acc_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_sched.sv
// Job sequencer for one dot-product PE: interleaves PIPE_LAT output elements so the
// accumulator feedback path stays busy, and tags each PE result for the drain.
module dot_acc_sched #(
  parameter int PIPE_LAT = 8,
  parameter int CNT_W    = 16,
  parameter int IDX_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] k_beats_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             pe_ena_o,
  output logic             pe_acc_zero_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    phase_q;
  logic [CNT_W-1:0]    pass_q;
  logic [CNT_W-1:0]    klast_q;
  logic                done_q;
  logic [PIPE_LAT-1:0] tag_vld_q;
  logic [PIPE_LAT-1:0] tag_fin_q;
  logic [IDX_W-1:0]    tag_idx_q [PIPE_LAT];

  logic blk_s;
  logic accept_s;
  logic pe_ena_s;
  logic last_beat_s;
  logic last_pass_s;
  logic pipe_empty_s;

  assign out_valid_o   = tag_vld_q[PIPE_LAT-1] & tag_fin_q[PIPE_LAT-1];
  assign out_idx_o     = tag_idx_q[PIPE_LAT-1];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

  // A held result freezes the whole PE so its value and tag stay stable for the drain.
  assign blk_s         = out_valid_o & ~out_ready_i;
  assign in_ready_o    = (state_q == ISSUE) & ~blk_s;
  assign accept_s      = in_valid_i & in_ready_o;
  assign pe_ena_s      = busy_o & ~blk_s & (in_valid_i | (state_q == DRAIN));
  assign pe_ena_o      = pe_ena_s;
  assign pe_acc_zero_o = ~((state_q == ISSUE) & (pass_q != {CNT_W{1'b0}}));

  assign last_pass_s   = (pass_q == klast_q);
  assign last_beat_s   = last_pass_s & (phase_q == IDX_W'(PIPE_LAT - 1));
  // Only the final stage may still hold a valid tag once the drain is about to finish.
  assign pipe_empty_s  = (tag_vld_q[PIPE_LAT-2:0] == {(PIPE_LAT-1){1'b0}});

  // Job FSM, beat counters and the tag pipe that mirrors the PE latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      phase_q   <= {IDX_W{1'b0}};
      pass_q    <= {CNT_W{1'b0}};
      klast_q   <= {CNT_W{1'b0}};
      done_q    <= 1'b0;
      tag_vld_q <= {PIPE_LAT{1'b0}};
      tag_fin_q <= {PIPE_LAT{1'b0}};
      for (int i = 0; i < PIPE_LAT; i++) tag_idx_q[i] <= {IDX_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      if (pe_ena_s) begin
        tag_vld_q    <= {tag_vld_q[PIPE_LAT-2:0], accept_s};
        tag_fin_q    <= {tag_fin_q[PIPE_LAT-2:0], last_pass_s};
        tag_idx_q[0] <= phase_q;
        for (int i = 1; i < PIPE_LAT; i++) tag_idx_q[i] <= tag_idx_q[i-1];
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (k_beats_i != {CNT_W{1'b0}}) begin
              klast_q <= k_beats_i - CNT_W'(1);
              pass_q  <= {CNT_W{1'b0}};
              phase_q <= {IDX_W{1'b0}};
              state_q <= ISSUE;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept_s) begin
            if (last_beat_s) begin
              state_q <= DRAIN;
            end else if (phase_q == IDX_W'(PIPE_LAT - 1)) begin
              phase_q <= {IDX_W{1'b0}};
              pass_q  <= pass_q + CNT_W'(1);
            end else begin
              phase_q <= phase_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pe_ena_s && pipe_empty_s) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc_sched.sv
// Randomized bench for dot_acc_sched: a clocked PE model consumes pe_ena/pe_acc_zero,
// and a scoreboard of per-element sums is checked whenever a tagged result is drained.
module tb_dot_acc_sched;
  localparam int N  = 8;
  localparam int CW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] k_beats = '0;
  logic          busy, done, in_ready, pe_ena, acc_zero, out_valid;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_idx;
  logic [31:0]   in_data = '0;
  logic [31:0]   pe_pipe [N] = '{default: 32'd0};
  int            cyc = 0;

  int            n_chk = 0, n_fail = 0;
  int            exp_idx_q[$];
  logic [31:0]   exp_val_q[$];
  int            pop_cyc_q[$];
  int            done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
  logic          busy_at_done = 1'b0;

  dot_acc_sched #(.PIPE_LAT(N), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_beats_i(k_beats),
    .busy_o(busy), .done_o(done), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pe_ena_o(pe_ena), .pe_acc_zero_o(acc_zero), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_idx_o(out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PE: PIPE_LAT enabled stages; the accumulator input is either zero or the PE's own result.
  always @(posedge clk) begin
    if (pe_ena) begin
      pe_pipe[0] <= in_data + (acc_zero ? 32'd0 : pe_pipe[N-1]);
      for (int i = 1; i < N; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pe_ena", pe_ena, 0);
    chk("rst_acc_zero", acc_zero, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
  endtask

  // Monitor: pops the scoreboard on every drained result and polices the stall rules.
  initial begin
    logic        stl = 1'b0;
    logic [IW-1:0] stl_idx = '0;
    logic [31:0] stl_res = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stl = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          chk("stall_pe_ena", pe_ena, 0);
          chk("stall_in_ready", in_ready, 0);
          if (stl) begin
            chk("stall_idx", out_idx, stl_idx);
            chk("stall_result", pe_pipe[N-1], stl_res);
          end
          stl = 1'b1;
          stl_idx = out_idx;
          stl_res = pe_pipe[N-1];
        end else begin
          stl = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_idx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: idx %0d result %0d with nothing expected", out_idx, pe_pipe[N-1]);
          end else begin
            chk("out_idx", out_idx, exp_idx_q.pop_front());
            chk("out_result", pe_pipe[N-1], exp_val_q.pop_front());
            pop_cyc_q.push_back(cyc);
            last_pop_cyc = cyc;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
    end
  end

  // mode 0: in_valid held high, mode 1: toggled every cycle. rst_pops>0 aborts via reset.
  task automatic run_job(input int k, input int mode, input int stall_idx, input int const_d,
                         input int bad_start, input int rst_pops);
    logic [31:0] beats[$];
    logic [31:0] sums [N];
    int nb, d0, ptr, t, stall_n, first_acc;
    bit aborted;
    nb = k * N;
    for (int e = 0; e < N; e++) sums[e] = 32'd0;
    for (int j = 0; j < nb; j++) begin
      logic [31:0] d;
      d = (const_d >= 0) ? 32'(const_d) : 32'($urandom_range(0, 60000));
      beats.push_back(d);
      sums[j % N] += d;
    end
    for (int e = 0; e < N; e++) begin
      exp_idx_q.push_back(e);
      exp_val_q.push_back(sums[e]);
    end
    d0 = done_cnt;
    pop_cyc_q.delete();
    start = 1'b1;
    k_beats = CW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    ptr = 0; t = 0; stall_n = 0; first_acc = -1; aborted = 1'b0;
    while (done_cnt == d0 && t < 3000) begin
      start = (t == bad_start);
      if (t == bad_start) k_beats = CW'(7);
      in_valid = (ptr < nb) && (mode == 0 || t[0] == 1'b0);
      in_data  = (ptr < nb) ? beats[ptr] : 32'd0;
      if (stall_idx >= 0 && out_valid && int'(out_idx) == stall_idx && stall_n < 5) begin
        out_ready = 1'b0;
        stall_n++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        chk("acc_zero", acc_zero, (ptr < N) ? 1 : 0);
        chk("accept_pe_ena", pe_ena, 1);
        if (first_acc < 0) first_acc = cyc;
        ptr++;
      end
      if (busy && in_ready && !in_valid) chk("no_bubble", pe_ena, 0);
      if (rst_pops > 0) begin
        #2;
        if (exp_idx_q.size() <= N - rst_pops) begin
          rst_n = 1'b0;
          #1;
          chk_reset_outputs();
          exp_idx_q.delete();
          exp_val_q.delete();
          aborted = 1'b1;
          @(posedge clk); #1;
          rst_n = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      chk("done_once", done_cnt - d0, 1);
      chk("beats_accepted", ptr, nb);
      chk("scoreboard_empty", exp_idx_q.size(), 0);
      chk("done_latency", done_cyc - last_pop_cyc, 1);
      chk("busy_at_done", busy_at_done, 0);
      if (mode == 0 && stall_idx < 0 && pop_cyc_q.size() == N) begin
        chk("first_out_latency", pop_cyc_q[0] - first_acc, nb);
        chk("out_burst", pop_cyc_q[N-1] - pop_cyc_q[0], N - 1);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(1, 0, -1, -1, -1, 0);
    run_job(3, 0, -1, 16, 10, 0);
    run_job(2, 1, -1, -1, -1, 0);
    run_job(2, 0, 3, -1, -1, 0);

    start = 1'b1;
    k_beats = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("k0_done", done, 1);
    chk("k0_busy", busy, 0);
    chk("k0_in_ready", in_ready, 0);
    @(negedge clk);
    chk("k0_done_pulse", done, 0);
    chk("k0_in_ready2", in_ready, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++)
      run_job($urandom_range(1, 4), $urandom_range(0, 1), -1, -1, -1, 0);

    run_job(1, 0, -1, -1, -1, 3);
    run_job(1, 0, -1, -1, -1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
